// File: rtl/serial_reg_loader.sv
// Serial register-write front end: synchronises a 3-pin serial port
// (cs_n / sck / sdi) into clk, deserialises MSB-first frames into
// {address, data} and issues one write_strobe per completed frame.
module serial_reg_loader #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n_pin,
  input  logic              sck_pin,
  input  logic              sdi_pin,
  output logic              write_strobe,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              frame_err,
  output logic [3:0]        frame_count
);

  localparam int unsigned FRAME_BITS = ADDR_W + DATA_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned FC_W       = 4;

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, sdi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_n_s, sck_s, sdi_s, sck_rise;

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   done_q, done_d;
  logic                   write_strobe_q, write_strobe_d;
  logic [ADDR_W-1:0]      address_q, address_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   frame_err_q, frame_err_d;
  logic [FC_W-1:0]        frame_count_q, frame_count_d;

  // Pin synchronisers plus the registered copy of sck used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_pin};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_pin};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_pin};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      done_q         <= 1'b0;
      write_strobe_q <= 1'b0;
      address_q      <= '0;
      data_q         <= '0;
      busy_q         <= 1'b0;
      frame_err_q    <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      done_q         <= done_d;
      write_strobe_q <= write_strobe_d;
      address_q      <= address_d;
      data_q         <= data_d;
      busy_q         <= busy_d;
      frame_err_q    <= frame_err_d;
      frame_count_q  <= frame_count_d;
    end
  end

  // Next-state logic: shift on sck rises, commit a completed frame one cycle later,
  // cs deassertion takes priority over a coincident sck rise
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    done_d         = 1'b0;
    write_strobe_d = 1'b0;
    address_d      = address_q;
    data_d         = data_q;
    frame_err_d    = 1'b0;
    frame_count_d  = frame_count_q;

    if (done_q) begin
      write_strobe_d        = 1'b1;
      {address_d, data_d}   = shift_q;
      frame_count_d         = frame_count_q + FC_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!cs_n_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_n_s) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0) frame_err_d = 1'b1;
        end else if (sck_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT) || (bit_cnt_d != '0);
  end

  assign write_strobe = write_strobe_q;
  assign address      = address_q;
  assign data         = data_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_serial_reg_loader.sv
// Randomised bench for serial_reg_loader: drives serial frames on the pins and
// checks strobes, payloads, strobe timing, frame errors and counters against
// a frame-level reference model.
module tb_serial_reg_loader;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst, cs_n_pin, sck_pin, sdi_pin;
  logic       write_strobe, busy, frame_err;
  logic [2:0] address;
  logic [4:0] data;
  logic [3:0] frame_count;

  serial_reg_loader #(.SYNC_STAGES(S), .ADDR_W(3), .DATA_W(5)) dut (
    .clk(clk), .rst(rst), .cs_n_pin(cs_n_pin), .sck_pin(sck_pin), .sdi_pin(sdi_pin),
    .write_strobe(write_strobe), .address(address), .data(data), .busy(busy),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] word; } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];

  int unsigned n_tests = 0, n_fail = 0;
  int          err_seen = 0, err_long = 0, err_m = 0;
  logic        err_prev = 1'b0;
  logic [3:0]  fc_m = '0;
  logic [7:0]  last_word = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe strobes and error pulses outside reset
  always @(negedge clk) begin
    if (rst) begin
      err_prev = 1'b0;
    end else begin
      if (write_strobe) obs_q.push_back('{cyc, {address, data}});
      if (frame_err) begin
        err_seen++;
        if (err_prev) err_long++;
      end
      err_prev = frame_err;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] outs();
    return 32'({write_strobe, address, data, busy, frame_err, frame_count});
  endfunction

  // Send the first nb bits of w MSB first; ph=0 picks random legal phase lengths
  task automatic send_bits(input logic [7:0] w, input int nb, input int ph);
    int lo, hi;
    for (int i = 0; i < nb; i++) begin
      lo = (ph == 0) ? int'($urandom_range(3, 8)) : ph;
      hi = (ph == 0) ? int'($urandom_range(3, 8)) : ph;
      sdi_pin = w[7-i];
      idle(lo);
      sck_pin = 1'b1;
      if (i == 7) begin
        exp_q.push_back('{cyc + int'(S) + 2, w});
        fc_m      = fc_m + 4'd1;
        last_word = w;
      end
      idle(hi);
      sck_pin = 1'b0;
    end
  endtask

  // Seven bits, then the eighth sck rise coincides with cs_n rising
  task automatic send7_then_collide(input logic [7:0] w);
    send_bits(w, 7, 0);
    sdi_pin = w[0];
    idle(4);
    sck_pin  = 1'b1;
    cs_n_pin = 1'b1;
    idle(4);
    sck_pin = 1'b0;
    err_m++;
    idle(S + 4);
  endtask

  // Close the cs session and compare everything observed against the model
  task automatic end_session();
    ev_t e, o;
    cs_n_pin = 1'b1;
    idle(S + 4);
    check("strobe_count", obs_q.size(), exp_q.size());
    if (obs_q.size() == exp_q.size()) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        check("strobe_cycle", o.cyc, e.cyc);
        check("strobe_word", o.word, e.word);
      end
    end
    exp_q.delete();
    obs_q.delete();
    check("frame_err_count", err_seen, err_m);
    check("frame_err_width", err_long, 0);
    check("frame_count", frame_count, fc_m);
    check("held_addr_data", {address, data}, last_word);
    check("busy_after_cs", busy, 0);
  endtask

  task automatic do_reset_mid_cycle();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", outs(), 0);
    cs_n_pin = 1'b1;
    sck_pin  = 1'b0;
    idle(3);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    err_seen = 0; err_long = 0; err_m = 0;
    fc_m = '0; last_word = '0;
    idle(4);
  endtask

  initial begin
    logic [7:0] w;
    int nf;
    rst = 1'b1; cs_n_pin = 1'b1; sck_pin = 1'b0; sdi_pin = 1'b0;
    idle(3);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    idle(4);
    check("idle_busy", busy, 0);

    // Single fixed frame, 10-clk phases
    cs_n_pin = 1'b0; idle(4);
    send_bits(8'b010_01010, 8, 10);
    check("busy_in_frame", busy, 1);
    end_session();
    check("t1_address", address, 3'd2);
    check("t1_data", data, 5'd10);

    // Back-to-back frames in one cs assertion
    cs_n_pin = 1'b0; idle(4);
    send_bits(8'h1F, 8, 0);
    send_bits(8'hE3, 8, 0);
    end_session();
    check("t2_address", address, 3'd7);
    check("t2_data", data, 5'd3);

    // Abort after 5 bits
    cs_n_pin = 1'b0; idle(4);
    w = 8'($urandom);
    send_bits(w, 5, 0);
    idle(3);
    err_m++;
    end_session();

    // cs_n rise collides with the 8th sck rise
    cs_n_pin = 1'b0; idle(4);
    send7_then_collide(8'($urandom));
    end_session();

    // Async reset mid-frame, then 0xA5
    cs_n_pin = 1'b0; idle(4);
    send_bits(8'($urandom), 4, 0);
    do_reset_mid_cycle();
    check("post_reset_busy", busy, 0);
    cs_n_pin = 1'b0; idle(4);
    send_bits(8'hA5, 8, 0);
    end_session();
    check("t5_address", address, 3'd5);
    check("t5_data", data, 5'd5);

    // Random sessions: valid frames, optionally followed by an abort or collision
    for (int s = 0; s < 8; s++) begin
      cs_n_pin = 1'b0; idle(int'($urandom_range(3, 6)));
      nf = int'($urandom_range(1, 3));
      for (int k = 0; k < nf; k++) send_bits(8'($urandom), 8, 0);
      case ($urandom_range(0, 2))
        0: ;
        1: begin
          send_bits(8'($urandom), int'($urandom_range(1, 7)), 0);
          idle(3);
          err_m++;
        end
        default: send7_then_collide(8'($urandom));
      endcase
      end_session();
    end

    // Frame counter wrap over 16 frames
    do_reset_mid_cycle();
    cs_n_pin = 1'b0; idle(4);
    for (int k = 0; k < 16; k++) begin
      send_bits(8'($urandom), 8, 3);
      idle(2);
      if (k == 14) check("count_before_wrap", frame_count, 4'd15);
    end
    check("count_wrapped", frame_count, 4'd0);
    end_session();

    // sck activity with cs_n high is ignored
    for (int k = 0; k < 6; k++) begin
      sdi_pin = 1'($urandom);
      sck_pin = 1'b1; idle(4);
      check("busy_cs_high", busy, 0);
      sck_pin = 1'b0; idle(4);
    end
    end_session();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
